// File: rtl/sede_frame_ctrl_if.sv
// Harness-side bus of the Sobel frame controller: start/status, image ROM
// read port, edge-engine pixel/result stream and result RAM write port.
interface sede_frame_ctrl_if #(parameter int AW = 10);
  logic          start, busy, done, err;
  logic [7:0]    frame_cnt;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          eng_rst, pix_en;
  logic [7:0]    pix_data;
  logic          eng_busy, eng_valid;
  logic [7:0]    eng_edge;
  logic          res_wr;
  logic [AW-1:0] res_addr;
  logic [7:0]    res_data;

  modport master (
    input  start, rom_data, eng_busy, eng_valid, eng_edge,
    output busy, done, err, frame_cnt, rom_rd, rom_addr, eng_rst,
           pix_en, pix_data, res_wr, res_addr, res_data
  );
  modport slave (
    output start, rom_data, eng_busy, eng_valid, eng_edge,
    input  busy, done, err, frame_cnt, rom_rd, rom_addr, eng_rst,
           pix_en, pix_data, res_wr, res_addr, res_data
  );
endinterface

// File: rtl/sede_frame_ctrl.sv
// Frame controller for the Sobel edge engine: resets the engine, feeds one
// frame from ROM under back-pressure, captures edge samples, reports done/err.
module sede_frame_ctrl #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int AW      = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  sede_frame_ctrl_if.master b
);
  localparam int            NPIX   = IMG_W * IMG_H;
  localparam int            CW     = AW + 1;
  localparam int            IW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] NPIX_C = CW'(NPIX);

  typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic          clr_q, clr_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          err_q, err_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          rd_fly_q, rd_fly_d;
  logic          skid_vld_q, skid_vld_d;
  logic [7:0]    skid_q, skid_d;
  logic          res_wr_q, res_wr_d;
  logic [AW-1:0] res_addr_q, res_addr_d;
  logic [7:0]    res_data_q, res_data_d;
  logic          feed, rd, pix, cap;

  always_comb begin
    feed = (state_q == FEED);
    // A pending skid byte blocks new reads so at most one byte is ever parked.
    rd   = feed && !b.eng_busy && !skid_vld_q && (rd_cnt_q < NPIX_C);
    pix  = feed && !b.eng_busy && (rd_fly_q || skid_vld_q);
    cap  = b.eng_valid && (state_q == FEED || state_q == DRAIN) && (out_cnt_q < NPIX_C);

    state_d    = state_q;
    clr_d      = 1'b0;
    rd_cnt_d   = rd_cnt_q + CW'(rd);
    in_cnt_d   = in_cnt_q + CW'(pix);
    out_cnt_d  = out_cnt_q + CW'(cap);
    idle_d     = '0;
    err_d      = err_q;
    fcnt_d     = fcnt_q;
    rd_fly_d   = rd;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    res_wr_d   = cap;
    res_addr_d = cap ? out_cnt_q[AW-1:0] : res_addr_q;
    res_data_d = cap ? b.eng_edge : res_data_q;

    if (rd_fly_q && b.eng_busy) begin
      skid_d     = b.rom_data;
      skid_vld_d = 1'b1;
    end else if (pix) begin
      skid_vld_d = 1'b0;
    end

    case (state_q)
      IDLE: if (b.start) begin
        state_d    = CLR;
        err_d      = 1'b0;
        rd_cnt_d   = '0;
        in_cnt_d   = '0;
        out_cnt_d  = '0;
        skid_vld_d = 1'b0;
      end
      CLR: begin
        clr_d = ~clr_q;
        if (clr_q) state_d = FEED;
      end
      FEED: if (in_cnt_d == NPIX_C) state_d = DRAIN;
      DRAIN: begin
        // Idle time is counted from the last capture write, one cycle after eng_valid.
        if (out_cnt_q == NPIX_C) begin
          state_d = DONE;
          fcnt_d  = fcnt_q + 8'd1;
        end else if (b.eng_valid) begin
          idle_d = '0;
        end else if (idle_q == IW'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          fcnt_d  = fcnt_q + 8'd1;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_q      <= 1'b0;
      rd_cnt_q   <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      idle_q     <= '0;
      err_q      <= 1'b0;
      fcnt_q     <= '0;
      rd_fly_q   <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      res_wr_q   <= 1'b0;
      res_addr_q <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      rd_cnt_q   <= rd_cnt_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
      fcnt_q     <= fcnt_d;
      rd_fly_q   <= rd_fly_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      res_wr_q   <= res_wr_d;
      res_addr_q <= res_addr_d;
      res_data_q <= res_data_d;
    end
  end

  assign b.busy      = (state_q != IDLE);
  assign b.done      = (state_q == DONE);
  assign b.err       = err_q;
  assign b.frame_cnt = fcnt_q;
  assign b.eng_rst   = (state_q == CLR);
  assign b.rom_rd    = rd;
  assign b.rom_addr  = rd_cnt_q[AW-1:0];
  assign b.pix_en    = pix;
  assign b.pix_data  = !pix ? 8'd0 : (skid_vld_q ? skid_q : b.rom_data);
  assign b.res_wr    = res_wr_q;
  assign b.res_addr  = res_addr_q;
  assign b.res_data  = res_data_q;

  a_no_pix_when_busy: assert property (@(posedge clk) disable iff (rst) !(b.pix_en && b.eng_busy));

endmodule

// File: tb/tb_sede_frame_ctrl.sv
// Randomized bench: ROM + delay-line engine model with a pixel/result scoreboard
// driven from the frame-level rules (raster order, counts, latencies).
module tb_sede_frame_ctrl;
  localparam int W = 8, H = 8, AW = 6, TO = 20, N = W * H;

  typedef struct { int t; logic [7:0] p; } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sede_frame_ctrl_if #(.AW(AW)) bus();
  sede_frame_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .b(bus));

  // Image ROM: pixel = address, one-cycle read latency.
  always @(posedge clk) if (bus.rom_rd) bus.rom_data <= 8'(bus.rom_addr);

  int   tests = 0, fails = 0, cyc = 0;
  int   in_idx, rd_idx, wr_idx, nvalid, done_cnt, rstc;
  int   lat, maxv, bmode, bwin;
  int   last_pix, last_wr, done_cyc, first_rd, first_pix;
  bit   skid_pend, skid_now, rst_drv, err_exp;
  logic [7:0] fc_exp;
  ev_t  eq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.busy, bus.done, bus.err, bus.frame_cnt, bus.rom_rd, bus.rom_addr,
                bus.eng_rst, bus.pix_en, bus.pix_data, bus.res_wr, bus.res_addr, bus.res_data});
  endfunction

  // One clock: drive inputs 1 time unit after the edge, sample 1 unit later.
  task automatic tick(input bit st);
    @(posedge clk); #1; cyc++;
    rst       = rst_drv;
    bus.start = st;
    if (bmode == 1) bus.eng_busy = ($urandom_range(0, 3) == 0);
    else if (bwin > 0) begin
      bus.eng_busy = 1'b1; bwin--;
      if (bwin == 0) skid_pend = 1'b1;
    end else begin
      bus.eng_busy = 1'b0; skid_now = skid_pend; skid_pend = 1'b0;
    end
    bus.eng_valid = 1'b0;
    bus.eng_edge  = 8'($urandom);
    if (eq.size() > 0 && nvalid < maxv && cyc >= eq[0].t + lat) begin
      bus.eng_valid = 1'b1;
      bus.eng_edge  = eq[0].p ^ 8'hA5;
      void'(eq.pop_front());
      nvalid++;
    end
    #1;
    if (bus.eng_rst) begin eq.delete(); rstc++; end
    if (bus.eng_busy) chk("bp_pix", bus.pix_en, 0);
    if (skid_now) begin
      chk("skid_pix", bus.pix_en, 1);
      chk("skid_nord", bus.rom_rd, 0);
      skid_now = 1'b0;
    end
    if (bus.rom_rd) begin
      if (rd_idx == 0) first_rd = cyc;
      chk("rd_addr", bus.rom_addr, rd_idx);
      rd_idx++;
      if (bmode == 2 && rd_idx == N / 2) bwin = 5;
    end
    if (bus.pix_en) begin
      if (in_idx == 0) first_pix = cyc;
      chk("pix_data", bus.pix_data, 8'(in_idx));
      eq.push_back('{cyc, bus.pix_data});
      in_idx++;
      last_pix = cyc;
    end
    if (bus.res_wr) begin
      chk("res_addr", bus.res_addr, wr_idx);
      chk("res_data", bus.res_data, 8'(wr_idx) ^ 8'hA5);
      wr_idx++;
      last_wr = cyc;
    end
    if (bus.done) begin
      done_cnt++; done_cyc = cyc; fc_exp++;
      chk("frame_cnt", bus.frame_cnt, fc_exp);
      chk("err", bus.err, err_exp);
      chk("done_busy", bus.busy, 1);
    end
  endtask

  task automatic run_frame(input int l, input int mv, input int bm, input bit ign, input int rst_at);
    int s;
    bit to;
    lat = l; maxv = mv; bmode = bm; bwin = 0; skid_pend = 0; skid_now = 0;
    in_idx = 0; rd_idx = 0; wr_idx = 0; nvalid = 0; done_cnt = 0; rstc = 0;
    eq.delete();
    to = (mv < N);
    err_exp = to;
    tick(1'b1); s = cyc;
    chk("idle_pre", bus.busy, 0);
    tick(1'b0);
    chk("busy_rise", bus.busy, 1);
    chk("err_clr", bus.err, 0);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      tick(ign && (k % 37 == 20));
      if (rst_at >= 0 && in_idx == rst_at) begin
        rst_drv = 1'b1;
        tick(1'b0);
        chk("rst_zero", outs(), 0);
        rst_drv = 1'b0; fc_exp = 0; eq.delete();
        tick(1'b0);
        chk("rst_idle", outs(), 0);
        return;
      end
    end
    chk("done_once", done_cnt, 1);
    chk("pix_total", in_idx, N);
    chk("eng_rst_len", rstc, 2);
    chk("wr_total", wr_idx, to ? mv : N);
    if (to) chk("to_lat", done_cyc - last_wr, TO);
    else    chk("done_lat", done_cyc - last_wr, 1);
    if (bm == 0) begin
      chk("first_rd", first_rd - s, 3);
      chk("first_pix", first_pix - s, 4);
      chk("last_pix", last_pix - s, N + 3);
    end
  endtask

  initial begin
    rst = 1'b1; rst_drv = 1'b1;
    bus.start = 0; bus.eng_busy = 0; bus.eng_valid = 0; bus.eng_edge = 0;
    fc_exp = 0; bmode = 0; bwin = 0; lat = 1; maxv = 0;
    skid_pend = 0; skid_now = 0; err_exp = 0;
    in_idx = 0; rd_idx = 0; wr_idx = 0; nvalid = 0; done_cnt = 0; rstc = 0;
    tick(1'b0); tick(1'b0);
    chk("rst_state", outs(), 0);
    rst_drv = 1'b0;
    tick(1'b0);
    chk("post_rst", outs(), 0);

    run_frame(2, N, 0, 1'b0, -1);               // nominal
    run_frame(4, N, 2, 1'b0, -1);               // 5-cycle back-pressure window, read in flight
    run_frame(60, N * 500 / 1024, 0, 1'b0, -1); // engine stops early -> timeout
    run_frame(3, N, 0, 1'b1, -1);               // stray starts; also clears err
    for (int i = 0; i < 6; i++)
      run_frame(int'($urandom_range(1, 12)), N, 1, i[0], -1);
    run_frame(2, N, 0, 1'b0, 19);               // reset mid-feed
    run_frame(2, N, 0, 1'b0, -1);               // clean frame after reset
    for (int i = 0; i < 256; i++)
      run_frame(1 + i % 3, N, 0, 1'b0, -1);     // back-to-back, frame_cnt wraps

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
